spike_packet_encoder: RTL and testbench

Output-side stage directly downstream of `neuron_core_256x256`. It captures the core's 256-bit spike vector at the end of each image, serialises the set bits into 8-bit neuron-index packets, buffers them in a FIFO, and exposes them to the management SoC over Wishbone at 0x3000_8000. Firmware drains one spike index per read instead of parsing a 256-bit vector.

---
 rtl/spike_packet_encoder.sv | 183 ++++++++++++++++++
 tb/tb_spike_packet_encoder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_packet_encoder.sv
// Serialises a 256-bit end-of-image spike vector into 8-bit neuron-index packets behind a Wishbone FIFO.
// Optional per-frame timestamp byte in each entry when SPIKE_ENC_TIMESTAMP_EN is defined.
module spike_packet_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_8000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spike_valid_i,
  input  logic [255:0] spike_vec_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         busy_o,
  output logic         frame_done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
`ifdef SPIKE_ENC_TIMESTAMP_EN
  localparam int EW = 16;
`else
  localparam int EW = 8;
`endif

  typedef enum logic {IDLE, SCAN} state_t;
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] sel;
  } wb_req_t;

  state_t         state, state_nxt;
  logic [255:0]   pending, pend_clr;
  logic [8:0]     frame_count;
  logic           dropped;
  logic [7:0]     low_idx;
  logic           capture, push, scan_done, drop;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level;
  logic [8:0]     level9;
  logic [7:0]     level_sat;
  logic           empty, full, pop, flush, clr_drop;
  logic [EW-1:0]  entry;
  logic [31:0]    rdata;
  wb_req_t        req;
  logic           hit;
  logic           unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:2], wbs_adr_i[1:0]};

  assign empty     = (level == '0);
  assign full      = (level == DEPTH_L);
  assign level9    = 9'(level);
  assign level_sat = level9[8] ? 8'hFF : level9[7:0];
  assign busy_o    = (state == SCAN);
  assign pend_clr  = pending & (pending - 256'd1);

  // Lowest set bit wins: the last assignment in a descending loop.
  always_comb begin
    low_idx = '0;
    for (int i = 255; i >= 0; i--)
      if (pending[i]) low_idx = 8'(i);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    scan_done = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (spike_valid_i) begin
        capture   = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        drop = spike_valid_i;
        if (pending == '0) begin
          scan_done = 1'b1;
          state_nxt = IDLE;
        end else if (!full) begin
          push = 1'b1;
          if (pend_clr == '0) begin
            scan_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending      <= '0;
      frame_count  <= '0;
      dropped      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= scan_done;
      if (capture) begin
        pending     <= spike_vec_i;
        frame_count <= '0;
      end else if (push) begin
        pending     <= pend_clr;
        frame_count <= frame_count + 9'd1;
      end
      if (drop)          dropped <= 1'b1;
      else if (clr_drop) dropped <= 1'b0;
    end

`ifdef SPIKE_ENC_TIMESTAMP_EN
  logic [7:0] ts;
  always_ff @(posedge clk or posedge rst)
    if (rst)            ts <= '0;
    else if (scan_done) ts <= ts + 8'd1;
  assign entry = {ts, low_idx};
`else
  assign entry = low_idx;
`endif

  // Wishbone decode; a request is taken only while ack is low, giving one-cycle acks.
  assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req.rd   = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o & ~wbs_we_i;
  assign req.wr   = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o &  wbs_we_i;
  assign req.sel  = wbs_adr_i[3:2];
  assign pop      = req.rd & (req.sel == 2'd0) & ~empty;
  assign flush    = req.wr & (req.sel == 2'd2) & wbs_dat_i[0];
  assign clr_drop = req.wr & (req.sel == 2'd2) & wbs_dat_i[1];

  always_comb begin
    rdata = '0;
    if (req.rd)
      case (req.sel)
        2'd0: if (!empty) rdata = {16'h8000, 16'(mem[rd_ptr])};
        2'd1: rdata = {7'd0, frame_count, level_sat, 4'd0, dropped, busy_o, full, empty};
        default: rdata = '0;
      endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= entry;

  // Flush beats a same-edge push, so that entry is discarded.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req.rd | req.wr;
      wbs_dat_o <= rdata;
    end
endmodule

// File: tb/tb_spike_packet_encoder.sv
// Scoreboard bench for spike_packet_encoder: expected DATA words are queued when frames are driven.
module tb_spike_packet_encoder;
  localparam logic [31:0] BASE = 32'h3000_8000;
`ifdef SPIKE_ENC_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         spike_valid_i;
  logic [255:0] spike_vec_i;
  logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i, wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic         busy_o, frame_done_o;

  int checks = 0;
  int errors = 0;
  int unsigned ts_model = 0;
  logic [31:0] sb[$];

  spike_packet_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .spike_valid_i(spike_valid_i), .spike_vec_i(spike_vec_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // Pulse a frame for one edge; returns 1 time unit after the capture edge.
  task automatic send_frame(input logic [255:0] v, input bit accept);
    logic [7:0] tsb;
    spike_valid_i = 1'b1;
    spike_vec_i   = v;
    if (accept) begin
      tsb = TS_EN ? 8'(ts_model) : 8'h00;
      for (int i = 0; i < 256; i++)
        if (v[i]) sb.push_back({16'h8000, tsb, 8'(i)});
      ts_model++;
    end
    @(posedge clk); #1;
    spike_valid_i = 1'b0;
  endtask

  task automatic watch(input int n, output int busy_cnt, output int fd_cnt);
    busy_cnt = 0;
    fd_cnt   = 0;
    for (int i = 0; i < n; i++) begin
      if (busy_o) busy_cnt++;
      if (frame_done_o) fd_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd, output bit got);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wd;
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        rd  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    bit got;
    wb_access(adr, 1'b0, 32'h0, rd, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: no ack for read at %h", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] rd;
    bit got;
    wb_access(adr, 1'b1, wd, rd, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: no ack for write at %h", adr);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst = 1'b1;
    spike_valid_i = 1'b0; spike_vec_i = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
    wait_cycles(3);
    checks++;
    if ({wbs_ack_o, wbs_dat_o, busy_o, frame_done_o} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b dat=%h busy=%b fd=%b expected all 0",
               wbs_ack_o, wbs_dat_o, busy_o, frame_done_o);
    end
    rst = 1'b0;
    wait_cycles(1);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_status: got %h expected %h", rd, 32'h0000_0001);
    end
  endtask

  task automatic test_three_spikes;
    logic [255:0] v;
    logic [31:0]  rd, exp;
    int bc, fc;
    v = '0; v[3] = 1'b1; v[200] = 1'b1; v[255] = 1'b1;
    send_frame(v, 1'b1);
    watch(10, bc, fc);
    checks++;
    if (bc != 3 || fc != 1) begin
      errors++;
      $display("FAIL three_busy_done: got busy=%0d done=%0d expected busy=3 done=1", bc, fc);
    end
    wb_read(BASE + 4, rd);
    checks++;
    if (rd[24:16] !== 9'd3 || rd[15:8] !== 8'd3) begin
      errors++;
      $display("FAIL three_status: got %h expected count=3 level=3", rd);
    end
    for (int i = 0; i < 3; i++) begin
      wb_read(BASE, rd);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL three_data: got %h expected %h", rd, exp);
      end
    end
    wb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL three_empty_read: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_empty_and_full;
    logic [31:0] rd, exp;
    int bc, fc;
    send_frame('0, 1'b1);
    watch(5, bc, fc);
    checks++;
    if (bc != 1 || fc != 1) begin
      errors++;
      $display("FAIL zero_busy_done: got busy=%0d done=%0d expected busy=1 done=1", bc, fc);
    end
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL zero_status: got %h expected %h", rd, 32'h0000_0001);
    end
    send_frame('1, 1'b1);
    wait_cycles(25);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0010_1006) begin
      errors++;
      $display("FAIL full_status: got %h expected %h", rd, 32'h0010_1006);
    end
    for (int i = 0; i < 256; i++) begin
      wb_read(BASE, rd);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL full_drain: got %h with scoreboard empty", rd);
      end else begin
        exp = sb.pop_front();
        if (rd !== exp) begin
          errors++;
          $display("FAIL full_drain: got %h expected %h", rd, exp);
        end
      end
    end
    wait_cycles(3);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0100_0001) begin
      errors++;
      $display("FAIL full_final_status: got %h expected %h", rd, 32'h0100_0001);
    end
  endtask

  task automatic test_dropped;
    logic [255:0] v, w;
    logic [31:0]  rd, exp;
    v = 256'hFF;
    w = '0; w[100] = 1'b1; w[101] = 1'b1;
    send_frame(v, 1'b1);
    send_frame(w, 1'b0);
    wait_cycles(12);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0008_0808) begin
      errors++;
      $display("FAIL drop_status: got %h expected %h", rd, 32'h0008_0808);
    end
    for (int i = 0; i < 8; i++) begin
      wb_read(BASE, rd);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL drop_data: got %h expected %h", rd, exp);
      end
    end
    wb_write(BASE + 8, 32'h2);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0008_0001) begin
      errors++;
      $display("FAIL drop_clear: got %h expected %h", rd, 32'h0008_0001);
    end
  endtask

  task automatic test_flush;
    logic [255:0] v;
    logic [31:0]  rd, exp;
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[4] = 1'b1; v[8] = 1'b1; v[16] = 1'b1;
    send_frame(v, 1'b1);
    wait_cycles(8);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0005_0500) begin
      errors++;
      $display("FAIL flush_pre: got %h expected %h", rd, 32'h0005_0500);
    end
    wb_write(BASE + 8, 32'h1);
    sb.delete();
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0005_0001) begin
      errors++;
      $display("FAIL flush_status: got %h expected %h", rd, 32'h0005_0001);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, exp;
    // Read issued on the first push edge sees an empty FIFO; next read overlaps a push.
    send_frame(256'hFFF, 1'b1);
    wb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL pop_empty_with_push: got %h expected %h", rd, 32'h0);
    end
    wb_read(BASE, rd);
    exp = sb.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL pushpop_data: got %h expected %h", rd, exp);
    end
    wait_cycles(15);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h000C_0B00) begin
      errors++;
      $display("FAIL pushpop_level: got %h expected %h", rd, 32'h000C_0B00);
    end
    for (int i = 0; i < 11; i++) begin
      wb_read(BASE, rd);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL pushpop_drain: got %h expected %h", rd, exp);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [31:0] rd;
    send_frame('1, 1'b1);
    wait_cycles(4);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({wbs_ack_o, wbs_dat_o, busy_o, frame_done_o} !== 35'd0) begin
      errors++;
      $display("FAIL reset_async: got ack=%b dat=%h busy=%b fd=%b expected all 0",
               wbs_ack_o, wbs_dat_o, busy_o, frame_done_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    ts_model = 0;
    wait_cycles(2);
    wb_read(BASE + 4, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_mid_status: got %h expected %h", rd, 32'h0000_0001);
    end
    wb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_data: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_timestamps;
    logic [255:0] v;
    logic [31:0]  rd, exp, last;
    int bc, fc;
    v = '0; v[7] = 1'b1;
    last = '0;
    for (int f = 0; f < 257; f++) begin
      send_frame(v, 1'b1);
      watch(2, bc, fc);
      wb_read(BASE, rd);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL ts_frame %0d: got %h expected %h", f, rd, exp);
      end
      last = rd;
    end
    checks++;
    if (last !== 32'h8000_0007) begin
      errors++;
      $display("FAIL ts_wrap: got %h expected %h", last, 32'h8000_0007);
    end
  endtask

  task automatic test_addr_miss;
    logic [31:0] rd;
    bit got;
    wb_access(32'h3000_9000, 1'b0, 32'h0, rd, got);
    checks++;
    if (got) begin
      errors++;
      $display("FAIL addr_miss: got ack=1 expected ack=0");
    end
    wb_read(BASE + 12, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reg_c_read: got %h expected %h", rd, 32'h0);
    end
  endtask

  initial begin
    test_reset;
    test_three_spikes;
    test_empty_and_full;
    test_dropped;
    test_flush;
    test_back_to_back;
    test_reset_mid_scan;
    test_timestamps;
    test_addr_miss;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
